// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared state encoding and timing constants for key debounce
package key_debounce_pkg;

  typedef enum logic [1:0] {
    ST_UP        = 2'd0,
    ST_WAIT_DOWN = 2'd1,
    ST_DOWN      = 2'd2,
    ST_WAIT_UP   = 2'd3
  } key_state_t;

  localparam int CLK_HZ = 50_000_000;

  function automatic int debounce_cycles_for_ms(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // 20 ms settle time at the board clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = debounce_cycles_for_ms(20);

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one pushbutton channel: synchronizer, settle counter, FSM, pulses
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic rls
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             pressed;
  logic [CNT_W-1:0] cnt;
  key_state_t       state;

  assign pressed = ~s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      state <= ST_UP;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
      rls   <= 1'b0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      press <= 1'b0;
      rls   <= 1'b0;
      case (state)
        ST_UP: begin
          if (pressed) begin
            state <= ST_WAIT_DOWN;
            cnt   <= '0;
          end
        end
        ST_WAIT_DOWN: begin
          if (!pressed) begin
            state <= ST_UP;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_DOWN;
            cnt   <= '0;
            level <= 1'b1;
            press <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DOWN: begin
          if (!pressed) begin
            state <= ST_WAIT_UP;
            cnt   <= '0;
          end
        end
        ST_WAIT_UP: begin
          // a bounce back to pressed keeps the key down without a pulse
          if (pressed) begin
            state <= ST_DOWN;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_UP;
            cnt   <= '0;
            level <= 1'b0;
            rls   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_UP;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounces the raw active-low KEY pins into clean levels and edge pulses
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = 20
) (
  input  logic                CLOCK_50,
  input  logic                reset_reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk  (CLOCK_50),
      .rst_n(reset_reset_n),
      .key_n(key_n_in[i]),
      .level(key_level[i]),
      .press(key_press[i]),
      .rls  (key_release[i])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce with an 8-cycle settle time
module tb_key_debounce;

  localparam int NK  = 4;
  localparam int DB  = 8;
  localparam int LAT = DB + 3;

  typedef struct {
    int cyc;
    int key;
    bit is_press;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key_n_in = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  ev_t mon_ev;

  key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (4)
  ) dut (
    .CLOCK_50     (clk),
    .reset_reset_n(rst_n),
    .key_n_in     (key_n_in),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    checks++;
    if ((key_press & key_release) !== '0) begin
      errors++;
      $display("FAIL both_pulses cyc %0d press %b release %b required no overlap", cyc, key_press, key_release);
    end
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] || key_release[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc %0d key %0d press %0b release %0b required none",
                   cyc, k, key_press[k], key_release[k]);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_ev.cyc !== cyc || mon_ev.key !== k || mon_ev.is_press !== key_press[k]) begin
            errors++;
            $display("FAIL pulse_match got cyc %0d key %0d press %0b required cyc %0d key %0d press %0b",
                     cyc, k, key_press[k], mon_ev.cyc, mon_ev.key, mon_ev.is_press);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_ev(input int at, input int key, input bit is_press);
    ev_t e;
    e.cyc = at;
    e.key = key;
    e.is_press = is_press;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    step(2);
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      errors++;
      $display("FAIL reset_hold got %b required 0", {key_level, key_press, key_release});
    end
    rst_n = 1'b1;
    step(5);
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      errors++;
      $display("FAIL reset_idle got %b required 0", {key_level, key_press, key_release});
    end
  endtask

  task automatic test_clean_press;
    key_n_in[0] = 1'b0;
    expect_ev(cyc + LAT, 0, 1'b1);
    step(LAT - 1);
    checks++;
    if (key_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL press_early got %b required 0", key_level[0]);
    end
    step(1);
    checks++;
    if (key_level !== 4'b0001) begin
      errors++;
      $display("FAIL press_level got %b required 0001", key_level);
    end
    step(9);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL press_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce;
    key_n_in[1] = 1'b0;
    step(5);
    key_n_in[1] = 1'b1;
    step(2);
    key_n_in[1] = 1'b0;
    expect_ev(cyc + LAT, 1, 1'b1);
    step(20);
    checks++;
    if (key_level[1] !== 1'b1 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bounce_press got level %b pending %0d required 1 and 0", key_level[1], exp_q.size());
    end
    key_n_in[1] = 1'b1;
    expect_ev(cyc + LAT, 1, 1'b0);
    step(20);
    checks++;
    if (key_level !== 4'b0001 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bounce_release got level %b pending %0d required 0001 and 0", key_level, exp_q.size());
    end
  endtask

  task automatic test_release_glitch;
    key_n_in[0] = 1'b1;
    step(5);
    key_n_in[0] = 1'b0;
    step(3);
    key_n_in[0] = 1'b1;
    expect_ev(cyc + LAT, 0, 1'b0);
    step(LAT - 1);
    checks++;
    if (key_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL release_early got %b required 1", key_level[0]);
    end
    step(1);
    checks++;
    if (key_level !== 4'b0000) begin
      errors++;
      $display("FAIL release_level got %b required 0000", key_level);
    end
    step(9);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL release_drain got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic test_simultaneous;
    key_n_in[3:2] = 2'b00;
    expect_ev(cyc + LAT, 2, 1'b1);
    expect_ev(cyc + LAT, 3, 1'b1);
    step(LAT + 4);
    checks++;
    if (key_level !== 4'b1100) begin
      errors++;
      $display("FAIL simul_press got %b required 1100", key_level);
    end
    key_n_in[2] = 1'b1;
    expect_ev(cyc + LAT, 2, 1'b0);
    step(LAT + 4);
    checks++;
    if (key_level !== 4'b1000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL simul_release got level %b pending %0d required 1000 and 0", key_level, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_wait;
    key_n_in[1] = 1'b0;
    step(8);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({key_level, key_press, key_release} !== '0) begin
      errors++;
      $display("FAIL async_reset got %b required 0", {key_level, key_press, key_release});
    end
    key_n_in = '1;
    step(3);
    rst_n = 1'b1;
    step(30);
    checks++;
    if (key_level !== 4'b0000 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL post_reset got level %b pending %0d required 0000 and 0", key_level, exp_q.size());
    end
  endtask

  task automatic test_held_through_reset;
    key_n_in[0] = 1'b0;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;
    expect_ev(cyc + LAT, 0, 1'b1);
    step(LAT - 1);
    checks++;
    if (key_level[0] !== 1'b0) begin
      errors++;
      $display("FAIL held_early got %b required 0", key_level[0]);
    end
    step(1);
    checks++;
    if (key_level[0] !== 1'b1) begin
      errors++;
      $display("FAIL held_level got %b required 1", key_level[0]);
    end
    step(20);
    checks++;
    if (key_level !== 4'b0001 || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL held_final got level %b pending %0d required 0001 and 0", key_level, exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_release_glitch;
    test_simultaneous;
    test_reset_mid_wait;
    test_held_through_reset;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
